// File: rtl/ipif_init_pkg.sv
// Shared definitions for the IPIF command initiator: FSM state encoding
// and the memory region indices of the bcrypt user logic.
package ipif_init_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        GAP,
        RESP
    } init_state_e;

    // Region indices as decoded by the slave's chip-select vector
    localparam int MEM_HANDSHAKE = 0;
    localparam int MEM_CORES     = 1;

endpackage

// File: rtl/ipif_cmd_initiator.sv
// Single-beat IPIF bus initiator. Accepts read/write commands on a
// valid/ready handshake, drives registered Bus2IP_* strobes until the
// matching IP2Bus ack, inserts one idle bus cycle so the slave always sees
// a CE falling edge, and then presents the result on a response handshake.
//
// Optional build macro: IPIF_INIT_TIMEOUT_EN -- abandons an access with an
// error after C_TIMEOUT cycles without an ack. Without it ACCESS waits
// indefinitely.
module ipif_cmd_initiator
    import ipif_init_pkg::*;
#(
    parameter int  C_SLV_AWIDTH = 32,
    parameter int  C_SLV_DWIDTH = 32,
    parameter int  C_NUM_MEM    = 3,
    parameter int  C_TIMEOUT    = 64,
    localparam int MEM_W        = (C_NUM_MEM > 1) ? $clog2(C_NUM_MEM) : 1,
    localparam int BE_W         = C_SLV_DWIDTH / 8
) (
    input  logic                    Bus2IP_Clk,
    input  logic                    Bus2IP_Resetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rnw,
    input  logic [MEM_W-1:0]        cmd_mem,
    input  logic [C_SLV_AWIDTH-1:0] cmd_addr,
    input  logic [C_SLV_DWIDTH-1:0] cmd_wdata,
    input  logic [BE_W-1:0]         cmd_be,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [C_SLV_DWIDTH-1:0] rsp_data,
    output logic                    rsp_error,

    output logic [C_SLV_AWIDTH-1:0] Bus2IP_Addr,
    output logic [C_NUM_MEM-1:0]    Bus2IP_CS,
    output logic                    Bus2IP_RNW,
    output logic [C_SLV_DWIDTH-1:0] Bus2IP_Data,
    output logic [BE_W-1:0]         Bus2IP_BE,
    output logic [C_NUM_MEM-1:0]    Bus2IP_RdCE,
    output logic [C_NUM_MEM-1:0]    Bus2IP_WrCE,
    output logic                    Bus2IP_Burst,
    output logic                    Bus2IP_RdReq,
    output logic                    Bus2IP_WrReq,

    input  logic [C_SLV_DWIDTH-1:0] IP2Bus_Data,
    input  logic                    IP2Bus_RdAck,
    input  logic                    IP2Bus_WrAck,
    input  logic                    IP2Bus_Error
);

    localparam logic [MEM_W:0] NUM_MEM_L = (MEM_W + 1)'(C_NUM_MEM);

    init_state_e state_q, state_d;

    logic                    cmd_ready_d;
    logic                    rsp_valid_d;
    logic [C_SLV_DWIDTH-1:0] rsp_data_d;
    logic                    rsp_error_d;
    logic [C_SLV_AWIDTH-1:0] addr_d;
    logic [C_NUM_MEM-1:0]    cs_d;
    logic                    rnw_d;
    logic [C_SLV_DWIDTH-1:0] data_d;
    logic [BE_W-1:0]         be_d;
    logic [C_NUM_MEM-1:0]    rdce_d;
    logic [C_NUM_MEM-1:0]    wrce_d;

    logic                    mem_ok;
    logic [C_NUM_MEM-1:0]    mem_onehot;
    logic                    ack;

`ifdef IPIF_INIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(C_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Burst and FIFO-style requests are never used by this initiator
    assign Bus2IP_Burst = 1'b0;
    assign Bus2IP_RdReq = 1'b0;
    assign Bus2IP_WrReq = 1'b0;

    assign mem_ok     = ({1'b0, cmd_mem} < NUM_MEM_L);
    assign mem_onehot = C_NUM_MEM'(1) << cmd_mem;

    // Next-state and next-output logic; every registered output defaults to hold
    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data;
        rsp_error_d = rsp_error;
        addr_d      = Bus2IP_Addr;
        cs_d        = Bus2IP_CS;
        rnw_d       = Bus2IP_RNW;
        data_d      = Bus2IP_Data;
        be_d        = Bus2IP_BE;
        rdce_d      = Bus2IP_RdCE;
        wrce_d      = Bus2IP_WrCE;
        ack         = Bus2IP_RNW ? IP2Bus_RdAck : IP2Bus_WrAck;
`ifdef IPIF_INIT_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_ready && cmd_valid) begin
                    rsp_data_d = '0;
                    if (mem_ok) begin
                        state_d     = ACCESS;
                        rsp_error_d = 1'b0;
                        addr_d      = cmd_addr;
                        cs_d        = mem_onehot;
                        rnw_d       = cmd_rnw;
                        data_d      = cmd_rnw ? '0 : cmd_wdata;
                        be_d        = cmd_be;
                        rdce_d      = cmd_rnw ? mem_onehot : '0;
                        wrce_d      = cmd_rnw ? '0 : mem_onehot;
`ifdef IPIF_INIT_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end else begin
                        state_d     = RESP;
                        rsp_error_d = 1'b1;
                    end
                end
            end

            ACCESS: begin
                if (ack) begin
                    state_d     = GAP;
                    rsp_error_d = rsp_error | IP2Bus_Error;
                    if (Bus2IP_RNW && !IP2Bus_Error)
                        rsp_data_d = IP2Bus_Data;
                    addr_d = '0;
                    cs_d   = '0;
                    rnw_d  = 1'b0;
                    data_d = '0;
                    be_d   = '0;
                    rdce_d = '0;
                    wrce_d = '0;
                end
`ifdef IPIF_INIT_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d     = GAP;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = '0;
                    addr_d      = '0;
                    cs_d        = '0;
                    rnw_d       = 1'b0;
                    data_d      = '0;
                    be_d        = '0;
                    rdce_d      = '0;
                    wrce_d      = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end

            GAP: begin
                state_d = RESP;
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and output registers; reset clears everything and drops any access
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q     <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            Bus2IP_Addr <= '0;
            Bus2IP_CS   <= '0;
            Bus2IP_RNW  <= 1'b0;
            Bus2IP_Data <= '0;
            Bus2IP_BE   <= '0;
            Bus2IP_RdCE <= '0;
            Bus2IP_WrCE <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_error   <= rsp_error_d;
            Bus2IP_Addr <= addr_d;
            Bus2IP_CS   <= cs_d;
            Bus2IP_RNW  <= rnw_d;
            Bus2IP_Data <= data_d;
            Bus2IP_BE   <= be_d;
            Bus2IP_RdCE <= rdce_d;
            Bus2IP_WrCE <= wrce_d;
        end
    end

`ifdef IPIF_INIT_TIMEOUT_EN
    // Counts ACCESS cycles spent waiting for an ack
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`endif

endmodule
